axi_terminator: RTL and testbench

AXI_TERMINATOR -- requirements
Module: axi_terminator

---
 rtl/axi_terminator_pkg.sv | 20 ++
 rtl/axi_if.sv | 80 ++++++++
 rtl/axi_terminator.sv | 144 ++++++++++++++
 tb/tb_axi_terminator.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_terminator_pkg.sv
// Shared definitions for the AXI terminator: response codes and FSM states.
// Imported by axi_terminator and by anything that needs to decode its responses.
package axi_terminator_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_if.sv
// Full AXI4 bus bundle; widths are set here and nowhere else.
// Modports: master (drives requests) and slave (drives responses).
interface axi_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock,
               awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock,
               arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock,
               awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock,
               arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_terminator.sv
// AXI4 slave that accepts every transaction, drops write data and
// returns a constant read value and a fixed response code.
// Ports: clock, reset (sync, active-high), axi (axi_if.slave).
module axi_terminator
    import axi_terminator_pkg::*;
#(
    parameter logic [1023:0] READ_DATA = '0,
    parameter logic [1:0]    RESPONSE  = RESP_OKAY
) (
    input  logic clock,
    input  logic reset,
    axi_if.slave axi
);

    localparam int DW = $bits(axi.rdata);
    localparam int IW = $bits(axi.awid);

    w_state_e        r_wstate;
    logic [IW-1:0]   r_awid;
    logic [7:0]      r_awlen;
    logic [7:0]      r_wcnt;

    r_state_e        r_rstate;
    logic [7:0]      r_arlen;
    logic [7:0]      r_rcnt;

    // Fields the terminator never looks at.
    logic w_unused;
    assign w_unused = ^{axi.awaddr, axi.awsize, axi.awburst, axi.awlock,
                        axi.awcache, axi.awprot, axi.awqos,
                        axi.wdata, axi.wstrb,
                        axi.araddr, axi.arsize, axi.arburst, axi.arlock,
                        axi.arcache, axi.arprot, axi.arqos};

    // Write engine. Every handshake-facing output is a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate    <= W_IDLE;
            r_awid      <= '0;
            r_awlen     <= '0;
            r_wcnt      <= '0;
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bid     <= '0;
            axi.bresp   <= '0;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    if (axi.awvalid && axi.awready) begin
                        r_awid      <= axi.awid;
                        r_awlen     <= axi.awlen;
                        r_wcnt      <= '0;
                        axi.awready <= 1'b0;
                        axi.wready  <= 1'b1;
                        r_wstate    <= W_DATA;
                    end else begin
                        // Also raises AWREADY on the first edge out of reset.
                        axi.awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (axi.wvalid) begin
                        r_wcnt <= r_wcnt + 8'd1;
                        // Early WLAST or the full AWLEN+1 beats end the burst.
                        if (axi.wlast || (r_wcnt == r_awlen)) begin
                            axi.wready <= 1'b0;
                            axi.bvalid <= 1'b1;
                            axi.bid    <= r_awid;
                            axi.bresp  <= RESPONSE;
                            r_wstate   <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        axi.bvalid  <= 1'b0;
                        axi.bid     <= '0;
                        axi.bresp   <= '0;
                        axi.awready <= 1'b1;
                        r_wstate    <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Read engine.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rstate    <= R_IDLE;
            r_arlen     <= '0;
            r_rcnt      <= '0;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rid     <= '0;
            axi.rdata   <= '0;
            axi.rresp   <= '0;
            axi.rlast   <= 1'b0;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (axi.arvalid && axi.arready) begin
                        r_arlen     <= axi.arlen;
                        r_rcnt      <= '0;
                        axi.arready <= 1'b0;
                        axi.rvalid  <= 1'b1;
                        axi.rid     <= axi.arid;
                        axi.rdata   <= READ_DATA[DW-1:0];
                        axi.rresp   <= RESPONSE;
                        axi.rlast   <= (axi.arlen == 8'd0);
                        r_rstate    <= R_DATA;
                    end else begin
                        axi.arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        if (axi.rlast) begin
                            axi.rvalid  <= 1'b0;
                            axi.rid     <= '0;
                            axi.rdata   <= '0;
                            axi.rresp   <= '0;
                            axi.rlast   <= 1'b0;
                            axi.arready <= 1'b1;
                            r_rstate    <= R_IDLE;
                        end else begin
                            // RLAST is precomputed for the beat after this one.
                            r_rcnt    <= r_rcnt + 8'd1;
                            axi.rlast <= ((r_rcnt + 8'd1) == r_arlen);
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_terminator.sv
// Self-checking bench for axi_terminator: scoreboard queues filled by
// stimulus tasks, drained by a negedge monitor on the B and R channels.
module tb_axi_terminator;
    import axi_terminator_pkg::*;

    localparam int IDW = 4;
    localparam int DW  = 32;
    localparam logic [DW-1:0] EXP_RDATA = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_if #(.ID_W(IDW), .ADDR_W(32), .DATA_W(DW)) bus ();

    axi_terminator dut (
        .clock (clk),
        .reset (rst),
        .axi   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
    } rbeat_t;

    rbeat_t         exp_r[$];
    logic [IDW-1:0] exp_b[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // ---------------- monitor ----------------
    bit             mon_en = 1'b0;
    logic           pb_v = 1'b0, pb_r = 1'b0;
    logic [IDW-1:0] pb_id;
    logic [1:0]     pb_resp;
    logic           pr_v = 1'b0, pr_r = 1'b0;
    rbeat_t         pr;
    rbeat_t         er;
    logic [IDW-1:0] eb;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                pb_v = 1'b0;
                pr_v = 1'b0;
            end else begin
                if (pb_v && !pb_r) begin
                    check("b_hold_valid", bus.bvalid, 1);
                    check("b_hold_id", bus.bid, pb_id);
                    check("b_hold_resp", bus.bresp, pb_resp);
                end
                if (bus.bvalid) begin
                    if (bus.bready) begin
                        if (exp_b.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL b_unexpected: bid %0h, none expected",
                                     bus.bid);
                        end else begin
                            eb = exp_b.pop_front();
                            check("b_id", bus.bid, eb);
                            check("b_resp", bus.bresp, RESP_OKAY);
                        end
                    end
                end else begin
                    check("b_idle_zero", {bus.bid, bus.bresp}, 0);
                end
                pb_v    = bus.bvalid;
                pb_r    = bus.bready;
                pb_id   = bus.bid;
                pb_resp = bus.bresp;

                if (pr_v && !pr_r) begin
                    check("r_hold_valid", bus.rvalid, 1);
                    check("r_hold_id", bus.rid, pr.id);
                    check("r_hold_data", bus.rdata, pr.data);
                    check("r_hold_resp", bus.rresp, pr.resp);
                    check("r_hold_last", bus.rlast, pr.last);
                end
                if (bus.rvalid) begin
                    if (bus.rready) begin
                        if (exp_r.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL r_unexpected: rid %0h, none expected",
                                     bus.rid);
                        end else begin
                            er = exp_r.pop_front();
                            check("r_id", bus.rid, er.id);
                            check("r_data", bus.rdata, er.data);
                            check("r_resp", bus.rresp, er.resp);
                            check("r_last", bus.rlast, er.last);
                        end
                    end
                end else begin
                    check("r_idle_zero",
                          {bus.rid, bus.rdata, bus.rresp, bus.rlast}, 0);
                end
                pr_v    = bus.rvalid;
                pr_r    = bus.rready;
                pr.id   = bus.rid;
                pr.data = bus.rdata;
                pr.resp = bus.rresp;
                pr.last = bus.rlast;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input logic [7:0] len,
                            input int last_at, input int bmax,
                            output int hs_cyc);
        bit ok;
        int nb;
        hs_cyc = -1;
        bus.awid    = id;
        bus.awlen   = len;
        bus.awaddr  = $urandom;
        bus.awsize  = 3'd2;
        bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        exp_b.push_back(id);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.awready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            timeout("aw_handshake");
            bus.awvalid = 1'b0;
            return;
        end
        step();
        hs_cyc = cyc;
        bus.awvalid = 1'b0;
        check("w_ready_lat", bus.wready, 1);
        nb = (last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(3) == 0) begin
                bus.wvalid = 1'b0;
                step();
            end
            bus.wvalid = 1'b1;
            bus.wdata  = $urandom;
            bus.wstrb  = 4'hF;
            bus.wlast  = (b == last_at);
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (bus.wready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                timeout("w_handshake");
                break;
            end
            check("b_early", bus.bvalid, 0);
            step();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        check("w_done_wready", bus.wready, 0);
        check("b_lat", bus.bvalid, 1);
        repeat ($urandom_range(bmax)) step();
        bus.bready = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.bvalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("b_handshake");
        step();
        bus.bready = 1'b0;
        check("aw_ready_again", bus.awready, 1);
    endtask

    // mode: 0 = RREADY always high, 1 = toggling, 2 = random
    task automatic do_read(input logic [IDW-1:0] id, input logic [7:0] len,
                           input int mode, output int hs_cyc);
        bit ok;
        int n;
        int t;
        int start;
        hs_cyc = -1;
        bus.arid    = id;
        bus.arlen   = len;
        bus.araddr  = $urandom;
        bus.arsize  = 3'd2;
        bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            timeout("ar_handshake");
            bus.arvalid = 1'b0;
            return;
        end
        step();
        hs_cyc = cyc;
        start  = cyc;
        bus.arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++)
            exp_r.push_back('{id, EXP_RDATA, RESP_OKAY, (b == int'(len))});
        check("r_lat", bus.rvalid, 1);
        n = 0;
        t = 0;
        bus.rready = (mode == 0) ? 1'b1 :
                     (mode == 1) ? 1'b0 : 1'($urandom_range(1));
        while (n < int'(len) + 1 && t < 2000) begin
            @(negedge clk);
            if (bus.rvalid && bus.rready) n++;
            step();
            t++;
            if (mode == 1)      bus.rready = ~bus.rready;
            else if (mode == 2) bus.rready = 1'($urandom_range(1));
        end
        bus.rready = 1'b0;
        check("r_beat_count", n, int'(len) + 1);
        if (mode == 0) check("r_back_to_back", cyc - start, int'(len) + 1);
        check("r_after_last", bus.rvalid, 0);
        check("ar_ready_again", bus.arready, 1);
        check("r_exp_drained", exp_r.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
        bus.awburst = '0; bus.awlock = 1'b0; bus.awcache = '0;
        bus.awprot = '0; bus.awqos = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arlock = 1'b0; bus.arcache = '0;
        bus.arprot = '0; bus.arqos = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // reset state
        repeat (3) step();
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rlast", bus.rlast, 0);
        rst = 1'b0;
        step();
        check("rel_awready", bus.awready, 1);
        check("rel_arready", bus.arready, 1);
        mon_en = 1'b1;

        // single write, single-beat
        do_write(4'd3, 8'd0, 0, 0, c1);
        // 4-beat read with RREADY high
        do_read(4'd5, 8'd3, 0, c1);
        // 2-beat read with stalls
        do_read(4'd2, 8'd1, 1, c1);
        // early WLAST after 3 of 8 beats
        do_write(4'd9, 8'd7, 2, 2, c1);
        // no WLAST at all: ends after AWLEN+1 beats
        do_write(4'd10, 8'd3, 99, 1, c1);

        // AW and AR in the same cycle
        fork
            do_write(4'd7, 8'd7, 7, 2, c1);
            do_read(4'd8, 8'd7, 0, c2);
        join
        check("aw_ar_same_cycle", c1, c2);

        // reset during beat 2 of an 8-beat read
        bus.arid    = 4'd11;
        bus.arlen   = 8'd7;
        bus.arvalid = 1'b1;
        c1 = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.arready) begin
                c1 = 1;
                break;
            end
        end
        if (c1 == 0) timeout("rst_ar_handshake");
        step();
        bus.arvalid = 1'b0;
        for (int b = 0; b < 8; b++)
            exp_r.push_back('{4'd11, EXP_RDATA, RESP_OKAY, (b == 7)});
        bus.rready = 1'b1;
        step();
        rst = 1'b1;
        step();
        exp_r.delete();
        bus.rready = 1'b0;
        check("mid_rst_rvalid", bus.rvalid, 0);
        check("mid_rst_rlast", bus.rlast, 0);
        check("mid_rst_arready", bus.arready, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_arready", bus.arready, 1);
        check("post_rst_awready", bus.awready, 1);
        do_read(4'd6, 8'd2, 2, c1);

        // randomized back-to-back traffic
        for (int i = 0; i < 20; i++) begin
            logic [7:0] l;
            l = 8'($urandom_range(15));
            do_write(4'($urandom), l,
                     ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'(l),
                     4, c1);
        end
        for (int i = 0; i < 10; i++)
            do_read(4'($urandom), 8'($urandom_range(31)),
                    int'($urandom_range(2)), c1);

        // maximum burst length
        do_read(4'd15, 8'd255, 2, c1);
        do_write(4'd14, 8'd255, 255, 2, c1);

        step();
        check("b_exp_drained", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
